// File: rtl/dds_ui_pkg.sv
// rtl/dds_ui_pkg.sv - shared front-panel key indices, repeat FSM encoding and digit width
package dds_ui_pkg;

    localparam int DIGIT_W = 4;

    localparam int BTN_INC  = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DEC  = 2;
    localparam int BTN_DOWN = 3;
    localparam int BTN_CLR  = 4;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - edge detect and hold-to-repeat FSM for the inc/dec key pair
module key_repeat
    import dds_ui_pkg::*;
#(
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter int CNT_W     = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic inc_level,
    input  logic dec_level,
    input  logic clear,
    output logic inc_press,
    output logic dec_press,
    output logic step_inc,
    output logic step_dec
);

    rpt_state_t       state_q, state_n;
    logic             owner_dec_q, owner_dec_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             pend_inc_q, pend_inc_n;
    logic             pend_dec_q, pend_dec_n;
    logic             inc_q, dec_q;

    logic evt_inc, evt_dec, owner_level, other_press;

    // Edge registers reset high so a key held through reset needs a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RPT_IDLE;
            owner_dec_q <= 1'b0;
            cnt_q       <= '0;
            pend_inc_q  <= 1'b0;
            pend_dec_q  <= 1'b0;
            inc_q       <= 1'b1;
            dec_q       <= 1'b1;
        end else begin
            state_q     <= state_n;
            owner_dec_q <= owner_dec_n;
            cnt_q       <= cnt_n;
            pend_inc_q  <= pend_inc_n;
            pend_dec_q  <= pend_dec_n;
            inc_q       <= inc_level;
            dec_q       <= dec_level;
        end
    end

    always_comb begin
        inc_press   = inc_level & ~inc_q;
        dec_press   = dec_level & ~dec_q;
        evt_inc     = inc_press | (pend_inc_q & inc_level);
        evt_dec     = dec_press | (pend_dec_q & dec_level);
        owner_level = owner_dec_q ? dec_level : inc_level;
        other_press = owner_dec_q ? inc_press : dec_press;
        state_n     = state_q;
        owner_dec_n = owner_dec_q;
        cnt_n       = cnt_q;
        pend_inc_n  = 1'b0;
        pend_dec_n  = 1'b0;
        step_inc    = 1'b0;
        step_dec    = 1'b0;

        case (state_q)
            RPT_IDLE: begin
                if (!clear && (evt_inc ^ evt_dec)) begin
                    step_inc    = evt_inc;
                    step_dec    = evt_dec;
                    state_n     = RPT_HOLD;
                    owner_dec_n = evt_dec;
                    cnt_n       = '0;
                end
            end
            RPT_HOLD, RPT_REPEAT: begin
                if (clear) begin
                    state_n = RPT_IDLE;
                    cnt_n   = '0;
                end else if (other_press) begin
                    // Hand the opposing press over to IDLE on the next cycle.
                    state_n    = RPT_IDLE;
                    cnt_n      = '0;
                    pend_inc_n = owner_dec_q;
                    pend_dec_n = ~owner_dec_q;
                end else if (!owner_level) begin
                    state_n = RPT_IDLE;
                    cnt_n   = '0;
                end else if (tick) begin
                    if ((state_q == RPT_HOLD   && cnt_q == CNT_W'(HOLD_MS - 1)) ||
                        (state_q == RPT_REPEAT && cnt_q == CNT_W'(REPEAT_MS - 1))) begin
                        step_inc = ~owner_dec_q;
                        step_dec = owner_dec_q;
                        state_n  = RPT_REPEAT;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_n = RPT_IDLE;
        endcase
    end

endmodule

// File: rtl/digit_editor.sv
// rtl/digit_editor.sv - front-panel digit array, edit cursor, blink and display outputs
module digit_editor
    import dds_ui_pkg::*;
#(
    parameter int                          NUM_DIGITS = 8,
    parameter logic [DIGIT_W-1:0]          DIGIT_MAX  = 4'hF,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] INIT_VALUE = 32'h2022214C,
    parameter int                          HOLD_MS    = 500,
    parameter int                          REPEAT_MS  = 100,
    parameter int                          BLINK_MS   = 250
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick_1ms,
    input  logic [4:0]                    btn_level,
    output logic [NUM_DIGITS*DIGIT_W-1:0] data_pool,
    output logic [$clog2(NUM_DIGITS)-1:0] cursor_idx,
    output logic [NUM_DIGITS-1:0]         cursor_led,
    output logic [NUM_DIGITS-1:0]         blink_mask,
    output logic                          edit_pulse
);

    localparam int CUR_W  = $clog2(NUM_DIGITS);
    localparam int MAX_A  = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int MAX_MS = (MAX_A > BLINK_MS) ? MAX_A : BLINK_MS;
    localparam int CNT_W  = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;

    logic [NUM_DIGITS*DIGIT_W-1:0] data_q, data_n;
    logic [CUR_W-1:0]              cursor_q, cursor_n;
    logic [CNT_W-1:0]              blink_cnt_q;
    logic                          blink_phase_q;
    logic                          edit_q, edit_n;
    logic                          up_q, down_q, clr_q;
    logic                          press_up, press_down, press_clr;
    logic                          press_inc, press_dec, step_inc, step_dec;
    logic                          blink_rst;
    logic [DIGIT_W-1:0]            cur_digit, new_digit;

    assign press_up   = btn_level[BTN_UP]   & ~up_q;
    assign press_down = btn_level[BTN_DOWN] & ~down_q;
    assign press_clr  = btn_level[BTN_CLR]  & ~clr_q;

    key_repeat #(
        .HOLD_MS   (HOLD_MS),
        .REPEAT_MS (REPEAT_MS),
        .CNT_W     (CNT_W)
    ) u_key_repeat (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick_1ms),
        .inc_level (btn_level[BTN_INC]),
        .dec_level (btn_level[BTN_DEC]),
        .clear     (press_clr),
        .inc_press (press_inc),
        .dec_press (press_dec),
        .step_inc  (step_inc),
        .step_dec  (step_dec)
    );

    // The digit op reads the pre-move cursor; the cursor update lands on the same edge.
    always_comb begin
        cur_digit = data_q[cursor_q*DIGIT_W +: DIGIT_W];
        new_digit = cur_digit;
        if (step_inc)
            new_digit = (cur_digit == DIGIT_MAX) ? '0 : cur_digit + DIGIT_W'(1);
        else if (step_dec)
            new_digit = (cur_digit == '0) ? DIGIT_MAX : cur_digit - DIGIT_W'(1);

        data_n   = data_q;
        cursor_n = cursor_q;
        edit_n   = 1'b0;
        if (press_clr) begin
            data_n = INIT_VALUE;
            edit_n = 1'b1;
        end else begin
            if (step_inc ^ step_dec) begin
                data_n[cursor_q*DIGIT_W +: DIGIT_W] = new_digit;
                edit_n = 1'b1;
            end
            if (press_up && !press_down)
                cursor_n = (cursor_q == CUR_W'(NUM_DIGITS - 1)) ? '0 : cursor_q + CUR_W'(1);
            else if (press_down && !press_up)
                cursor_n = (cursor_q == '0) ? CUR_W'(NUM_DIGITS - 1) : cursor_q - CUR_W'(1);
        end
    end

    assign blink_rst = press_inc | press_dec | press_up | press_down | press_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q        <= INIT_VALUE;
            cursor_q      <= '0;
            edit_q        <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            up_q          <= 1'b1;
            down_q        <= 1'b1;
            clr_q         <= 1'b1;
        end else begin
            data_q   <= data_n;
            cursor_q <= cursor_n;
            edit_q   <= edit_n;
            up_q     <= btn_level[BTN_UP];
            down_q   <= btn_level[BTN_DOWN];
            clr_q    <= btn_level[BTN_CLR];
            if (blink_rst) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= 1'b0;
            end else if (tick_1ms) begin
                if (blink_cnt_q == CNT_W'(BLINK_MS - 1)) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign data_pool  = data_q;
    assign cursor_idx = cursor_q;
    assign cursor_led = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << cursor_q;
    assign blink_mask = blink_phase_q ? cursor_led : '0;
    assign edit_pulse = edit_q;

endmodule

// File: tb/tb_digit_editor.sv
// tb/tb_digit_editor.sv - directed self-checking bench for digit_editor
module tb_digit_editor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_1ms;
    logic [4:0]  btn_level;
    logic [4:0]  btn2_level;
    logic [31:0] data_pool, data2_pool;
    logic [2:0]  cursor_idx, cursor2_idx;
    logic [7:0]  cursor_led, cursor2_led;
    logic [7:0]  blink_mask, blink2_mask;
    logic        edit_pulse, edit2_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    digit_editor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1ms   (tick_1ms),
        .btn_level  (btn_level),
        .data_pool  (data_pool),
        .cursor_idx (cursor_idx),
        .cursor_led (cursor_led),
        .blink_mask (blink_mask),
        .edit_pulse (edit_pulse)
    );

    digit_editor #(
        .DIGIT_MAX  (4'h9),
        .INIT_VALUE (32'h00000009)
    ) dut_dec (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1ms   (tick_1ms),
        .btn_level  (btn2_level),
        .data_pool  (data2_pool),
        .cursor_idx (cursor2_idx),
        .cursor_led (cursor2_led),
        .blink_mask (blink2_mask),
        .edit_pulse (edit2_pulse)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick_1ms = 1'b1;
            step();
            tick_1ms = 1'b0;
            step();
        end
    endtask

    task automatic press(input int k);
        btn_level[k] = 1'b1;
        step();
        btn_level[k] = 1'b0;
        step();
    endtask

    logic [7:0] walk [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

    initial begin
        rst_n      = 1'b0;
        tick_1ms   = 1'b0;
        btn_level  = '0;
        btn2_level = '0;
        repeat (3) step();

        // reset state
        check("rst_data", data_pool, 32'h2022214C);
        check("rst_led", cursor_led, 8'h01);
        check("rst_idx", cursor_idx, 3'd0);
        check("rst_blink", blink_mask, 8'h00);
        check("rst_edit", edit_pulse, 1'b0);
        rst_n = 1'b1;
        repeat (2) step();

        // increment with hex wrap
        btn_level[0] = 1'b1; step();
        check("inc1_data", data_pool, 32'h2022214D);
        check("inc1_edit", edit_pulse, 1'b1);
        btn_level[0] = 1'b0; step();
        check("inc1_edit_low", edit_pulse, 1'b0);
        press(0);
        check("inc2_data", data_pool, 32'h2022214E);
        press(0);
        check("inc3_data", data_pool, 32'h2022214F);
        press(0);
        check("inc_wrap", data_pool, 32'h20222140);

        // decimal instance wraps
        btn2_level[0] = 1'b1; step(); btn2_level[0] = 1'b0; step();
        check("dec9_inc_wrap", data2_pool, 32'h00000000);
        btn2_level[2] = 1'b1; step(); btn2_level[2] = 1'b0; step();
        check("dec9_dec_wrap", data2_pool, 32'h00000009);

        // cursor walk and wrap
        for (int i = 0; i < 8; i++) begin
            press(1);
            check($sformatf("walk%0d", i), cursor_led, walk[i]);
        end
        press(3);
        check("down_wrap_led", cursor_led, 8'h80);
        check("down_wrap_idx", cursor_idx, 3'd7);
        press(1);
        check("up_back", cursor_led, 8'h01);
        check("walk_data", data_pool, 32'h20222140);

        // hold-to-repeat timing
        btn_level[0] = 1'b1; step();
        check("hold_press", data_pool, 32'h20222141);
        tick_n(499);
        check("hold_499", data_pool, 32'h20222141);
        tick_n(1);
        check("hold_500", data_pool, 32'h20222142);
        tick_n(99);
        check("rpt_99", data_pool, 32'h20222142);
        tick_n(1);
        check("rpt_100", data_pool, 32'h20222143);
        tick_n(200);
        check("rpt_300", data_pool, 32'h20222145);
        btn_level[0] = 1'b0; step();
        tick_n(300);
        check("release_idle", data_pool, 32'h20222145);

        // simultaneous events
        press(1); press(1);
        check("cur2", cursor_led, 8'h04);
        btn_level = 5'b00011; step();
        check("incup_data", data_pool, 32'h20222245);
        check("incup_led", cursor_led, 8'h08);
        btn_level = '0; step();
        btn_level = 5'b00101; step();
        check("incdec_data", data_pool, 32'h20222245);
        check("incdec_edit", edit_pulse, 1'b0);
        btn_level = '0; step();
        btn_level = 5'b10001; step();
        check("clr_data", data_pool, 32'h2022214C);
        check("clr_edit", edit_pulse, 1'b1);
        check("clr_led", cursor_led, 8'h08);
        step();
        check("clr_edit_once", edit_pulse, 1'b0);
        btn_level = '0; step();

        // opposing key during hold hands over next cycle
        btn_level = 5'b00001; step();
        check("own_inc", data_pool, 32'h2022314C);
        btn_level = 5'b00101; step();
        check("other_wait", edit_pulse, 1'b0);
        step();
        check("other_dec", data_pool, 32'h2022214C);
        check("other_edit", edit_pulse, 1'b1);
        btn_level = '0; step();

        // reset mid-repeat
        btn_level = 5'b00001; step();
        tick_n(500);
        check("pre_rst_rpt", data_pool, 32'h2022414C);
        tick_n(50);
        rst_n = 1'b0;
        repeat (3) step();
        check("mid_rst_data", data_pool, 32'h2022214C);
        check("mid_rst_led", cursor_led, 8'h01);
        check("mid_rst_blink", blink_mask, 8'h00);
        check("mid_rst_edit", edit_pulse, 1'b0);
        rst_n = 1'b1; step();
        tick_n(600);
        check("held_no_step", data_pool, 32'h2022214C);
        btn_level = '0; step();
        press(0);
        check("fresh_press", data_pool, 32'h2022214D);

        // blink cadence
        tick_n(249);
        check("blink_249", blink_mask, 8'h00);
        tick_n(1);
        check("blink_250", blink_mask, 8'h01);
        tick_n(249);
        check("blink_499", blink_mask, 8'h01);
        tick_n(1);
        check("blink_500", blink_mask, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
